// File: rtl/uart8_transmitter.sv
// ---------------------------------------------------------------------------
// uart8_transmitter
//
// 8N1/8N2 UART transmitter (optionally 8E1/8E2) with a one-byte holding
// register, so a second byte can be queued while a frame is on the line.
// When a byte is queued, its frame follows the previous one with no idle
// cycles in between.
//
// Optional feature macro:
//   UART8_TX_PARITY_EN  - when defined, inserts an even-parity bit between
//                         the last data bit and the stop bit(s).
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit (16x oversample clock)
//   STOP_BITS    - stop bits per frame, 1 or 2
//
// Ports:
//   clk   in   single clock, all logic on posedge
//   rst   in   synchronous active-high reset (priority over en and start)
//   en    in   enable; low aborts any frame and forces idle
//   start in   request to send 'in'; accepted when start && ready
//   in    in   [7:0] byte to transmit
//   out   out  serial tx line, idle high
//   ready out  holding register empty; a byte can be accepted
//   busy  out  a frame is on the line (start bit through last stop bit)
//   done  out  one-cycle pulse during the last stop-bit cycle
//   err   out  one-cycle pulse after start was asserted while ready was low
// ---------------------------------------------------------------------------
module uart8_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Bit-period counter width; guard against a degenerate 1-cycle bit.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef UART8_TX_PARITY_EN
    PARITY_BIT = 3'd3,
`endif
    STOP_BIT   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;          // cycle within current bit
  logic [2:0]       idx_reg, idx_next;          // data bit index, LSB first
  logic             stop_idx_reg, stop_idx_next;
  logic [7:0]       hold_reg, hold_next;        // holding register
  logic             hold_full_reg, hold_full_next;
  logic [7:0]       shift_reg, shift_next;      // byte currently on the line
  logic             out_reg, out_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic bit_last;
  logic stop_last;

  assign bit_last  = (cnt_reg == CNT_LAST);
  assign stop_last = (stop_idx_reg == STOP_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      stop_idx_reg  <= 1'b0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      shift_reg     <= '0;
      out_reg       <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      stop_idx_reg  <= stop_idx_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      shift_reg     <= shift_next;
      out_reg       <= out_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    stop_idx_next  = stop_idx_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    shift_next     = shift_reg;
    err_next       = 1'b0;

    if (!en) begin
      // Abort everything: idle line, empty holding register, counters cleared.
      state_next     = IDLE;
      cnt_next       = '0;
      idx_next       = '0;
      stop_idx_next  = 1'b0;
      hold_next      = '0;
      hold_full_next = 1'b0;
    end else begin
      // Host side: accept only against the registered ready of this cycle,
      // so a start coinciding with the hand-off to the shifter is rejected.
      if (start) begin
        if (!hold_full_reg) begin
          hold_next      = in;
          hold_full_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end

      if (state_reg != IDLE) begin
        cnt_next = bit_last ? '0 : cnt_reg + CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (hold_full_reg) begin
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
            cnt_next       = '0;
            state_next     = START_BIT;
          end
        end

        START_BIT: begin
          if (bit_last) begin
            idx_next   = 3'd0;
            state_next = DATA_BITS;
          end
        end

        DATA_BITS: begin
          if (bit_last) begin
            // Index wraps 7->0 naturally as the last data bit completes.
            idx_next = idx_reg + 3'd1;
            if (idx_reg == 3'd7) begin
              stop_idx_next = 1'b0;
`ifdef UART8_TX_PARITY_EN
              state_next    = PARITY_BIT;
`else
              state_next    = STOP_BIT;
`endif
            end
          end
        end

`ifdef UART8_TX_PARITY_EN
        PARITY_BIT: begin
          if (bit_last) begin
            stop_idx_next = 1'b0;
            state_next    = STOP_BIT;
          end
        end
`endif

        STOP_BIT: begin
          if (bit_last) begin
            if (stop_last) begin
              stop_idx_next = 1'b0;
              if (hold_full_reg) begin
                // Back-to-back: next start bit immediately, no idle cycle.
                shift_next     = hold_reg;
                hold_full_next = 1'b0;
                state_next     = START_BIT;
              end else begin
                state_next = IDLE;
              end
            end else begin
              stop_idx_next = stop_idx_reg + 1'b1;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so the line and status
  // flags change on the same edge as the state and are glitch-free.
  // -------------------------------------------------------------------------
  always_comb begin
    out_next  = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP_BIT) && (cnt_next == CNT_LAST) &&
                (stop_idx_next == STOP_LAST);
    case (state_next)
      START_BIT:  out_next = 1'b0;
      DATA_BITS:  out_next = shift_next[idx_next];
`ifdef UART8_TX_PARITY_EN
      PARITY_BIT: out_next = ^shift_next;   // even parity
`endif
      default:    out_next = 1'b1;
    endcase
  end

  assign out   = out_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign err   = err_reg;
  assign ready = ~hold_full_reg;

endmodule

// File: tb/tb_uart8_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart8_transmitter
//
// Each scenario schedules host stimulus per cycle, builds the expected
// waveforms of out/busy/done/ready/err from the frame format (start bit,
// data LSB first, optional even parity, stop bits, CLKS_PER_BIT cycles per
// bit), runs the DUT and compares the captured traces cycle by cycle.
// Cycle 0 of a run is the cycle in which the first start is presented.
// ---------------------------------------------------------------------------
module tb_uart8_transmitter;

  localparam int CPB   = 16;
  localparam int STOPB = 1;
`ifdef UART8_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 9 + PAR + STOPB;
  localparam int FC    = NBITS * CPB;     // cycles per frame
  localparam int MAXC  = 512;

  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [7:0] in;
  logic       out, ready, busy, done, err;

  always #5 clk = ~clk;

  uart8_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .start(start),
    .in   (in),
    .out  (out),
    .ready(ready),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  int checks   = 0;
  int failures = 0;

  // Stimulus plan
  logic       s_start [MAXC];
  logic       s_en    [MAXC];
  logic       s_rst   [MAXC];
  logic [7:0] s_in    [MAXC];
  // Traces: 0 out, 1 busy, 2 done, 3 ready, 4 err
  logic       o_tr [5][MAXC];
  logic       e_tr [5][MAXC];
  int         mm [5];
  int         ff [5];
  string      sig_name [5];

  task automatic clear_plan();
    for (int t = 0; t < MAXC; t++) begin
      s_start[t] = 1'b0;
      s_en[t]    = 1'b1;
      s_rst[t]   = 1'b0;
      s_in[t]    = 8'($urandom);
      e_tr[0][t] = 1'b1;
      e_tr[1][t] = 1'b0;
      e_tr[2][t] = 1'b0;
      e_tr[3][t] = 1'b1;
      e_tr[4][t] = 1'b0;
    end
  endtask

  task automatic plan_start(input int t, input logic [7:0] b);
    s_start[t] = 1'b1;
    s_in[t]    = b;
  endtask

  // Reference frame: start 0, data LSB first, [even parity], stop ones.
  task automatic add_frame(input int s, input logic [7:0] b);
    logic bits [12];
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k + 1] = b[k];
    for (int k = 9; k < 12; k++) bits[k] = 1'b1;
    if (PAR == 1) bits[9] = ^b;
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (s + k * CPB + c < MAXC) begin
          e_tr[0][s + k * CPB + c] = bits[k];
          e_tr[1][s + k * CPB + c] = 1'b1;
        end
      end
    end
    if (s + FC - 1 < MAXC) e_tr[2][s + FC - 1] = 1'b1;
  endtask

  // Frame aborted: line idle from cycle t0 on.
  task automatic idle_from(input int t0);
    for (int t = t0; t < MAXC; t++) begin
      e_tr[0][t] = 1'b1;
      e_tr[1][t] = 1'b0;
      e_tr[2][t] = 1'b0;
    end
  endtask

  task automatic ready_low(input int a, input int b);
    for (int t = a; t <= b; t++) e_tr[3][t] = 1'b0;
  endtask

  // Apply plan for n cycles, capture traces, count per-signal differences.
  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      rst   = s_rst[t];
      en    = s_en[t];
      start = s_start[t];
      in    = s_in[t];
      if (start)
        $display("tx cycle=%0d start in=0x%02h en=%0b rst=%0b", t, in, en, rst);
      @(negedge clk);
      o_tr[0][t] = out;
      o_tr[1][t] = busy;
      o_tr[2][t] = done;
      o_tr[3][t] = ready;
      o_tr[4][t] = err;
      if (done) $display("tx cycle=%0d done", t);
      @(posedge clk);
      #1;
    end
    rst   = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mm[k] = 0;
      ff[k] = -1;
      for (int t = 0; t < n; t++) begin
        if (o_tr[k][t] !== e_tr[k][t]) begin
          mm[k]++;
          if (ff[k] < 0) ff[k] = t;
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst   = 1'b1;
    en    = 1'b1;
    start = 1'b1;
    in    = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++; if (out !== 1'b1)   begin failures++; $display("FAIL reset_out got=%b need=1", out); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b need=1", ready); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b need=0", busy); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b need=0", done); end
    checks++; if (err !== 1'b0)   begin failures++; $display("FAIL reset_err got=%b need=0", err); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_hold_busy got=%b need=0 (start during rst leaked)", busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    int n, d0;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'hA5 : (i == 1) ? 8'h07 : 8'($urandom);
      clear_plan();
      plan_start(0, b);
      add_frame(2, b);
      ready_low(1, 1);
      n = FC + 8;
      run(n);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (mm[k] !== 0) begin
          failures++;
          $display("FAIL single_%0h_%s %0d cycles differ, first cycle %0d got=%b need=%b",
                   b, sig_name[k], mm[k], ff[k], o_tr[k][ff[k]], e_tr[k][ff[k]]);
        end
      end
      d0 = -1;
      for (int t = 0; t < n; t++) if (o_tr[2][t] === 1'b1 && d0 < 0) d0 = t;
      checks++;
      if (d0 !== 2 + FC - 1) begin
        failures++;
        $display("FAIL single_%0h_done_cycle got=%0d need=%0d", b, d0, 2 + FC - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    int n, d0, d1;
    for (int i = 0; i < 2; i++) begin
      b0 = (i == 0) ? 8'h55 : 8'($urandom);
      b1 = (i == 0) ? 8'h0F : 8'($urandom);
      clear_plan();
      plan_start(0, b0);
      plan_start(5, b1);                      // queued while busy
      plan_start(20, 8'($urandom));           // holding full -> rejected
      plan_start(2 + FC - 1, 8'($urandom));   // same cycle as hand-off -> rejected
      add_frame(2, b0);
      add_frame(2 + FC, b1);
      ready_low(1, 1);
      ready_low(6, 2 + FC - 1);
      e_tr[4][21]     = 1'b1;
      e_tr[4][2 + FC] = 1'b1;
      n = 2 + 2 * FC + 8;
      run(n);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (mm[k] !== 0) begin
          failures++;
          $display("FAIL b2b_%0h_%0h_%s %0d cycles differ, first cycle %0d got=%b need=%b",
                   b0, b1, sig_name[k], mm[k], ff[k], o_tr[k][ff[k]], e_tr[k][ff[k]]);
        end
      end
      d0 = -1;
      d1 = -1;
      for (int t = 0; t < n; t++) begin
        if (o_tr[2][t] === 1'b1) begin
          if (d0 < 0) d0 = t;
          else if (d1 < 0) d1 = t;
        end
      end
      checks++;
      if (d1 - d0 !== FC || d0 < 0 || d1 < 0) begin
        failures++;
        $display("FAIL b2b_done_spacing got=%0d (d0=%0d d1=%0d) need=%0d", d1 - d0, d0, d1, FC);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b, y;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? 8'hA5 : 8'($urandom);
      y = 8'($urandom);
      clear_plan();
      plan_start(0, b);
      plan_start(10, 8'($urandom));   // queued, must be lost on reset
      s_rst[50] = 1'b1;
      plan_start(50, 8'($urandom));   // rst has priority: no err, no accept
      plan_start(60, y);
      add_frame(2, b);
      idle_from(51);
      add_frame(62, y);
      ready_low(1, 1);
      ready_low(11, 50);
      ready_low(61, 61);
      run(62 + FC + 8);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (mm[k] !== 0) begin
          failures++;
          $display("FAIL rst_mid_%0h_%s %0d cycles differ, first cycle %0d got=%b need=%b",
                   b, sig_name[k], mm[k], ff[k], o_tr[k][ff[k]], e_tr[k][ff[k]]);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] b, y;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      y = 8'($urandom);
      clear_plan();
      plan_start(0, b);
      plan_start(10, 8'($urandom));   // queued, must be dropped by en low
      s_en[70] = 1'b0;
      s_en[71] = 1'b0;
      s_en[72] = 1'b0;
      plan_start(71, 8'($urandom));   // ignored while disabled
      plan_start(80, y);
      add_frame(2, b);
      idle_from(71);
      add_frame(82, y);
      ready_low(1, 1);
      ready_low(11, 70);
      ready_low(81, 81);
      run(82 + FC + 8);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (mm[k] !== 0) begin
          failures++;
          $display("FAIL en_drop_%0h_%s %0d cycles differ, first cycle %0d got=%b need=%b",
                   b, sig_name[k], mm[k], ff[k], o_tr[k][ff[k]], e_tr[k][ff[k]]);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    sig_name[0] = "out";
    sig_name[1] = "busy";
    sig_name[2] = "done";
    sig_name[3] = "ready";
    sig_name[4] = "err";
    rst   = 1'b1;
    en    = 1'b1;
    start = 1'b0;
    in    = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart8_transmitter.md
UART8_TRANSMITTER -- requirements
Module: uart8_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (16x oversample clock, matching the receiver).
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  single clock, 16x baud rate; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  enable; low forces idle.
REQ-006 SHALL have port start  input  1  request to send the byte on in; accepted when start && ready.
REQ-007 SHALL have port in  input  8  byte to transmit.
REQ-008 SHALL have port out  output  1  serial tx line, idle high.
REQ-009 SHALL have port ready  output  1  holding register empty; a byte can be accepted.
REQ-010 SHALL have port busy  output  1  a frame is on the line (start bit through last stop bit).
REQ-011 SHALL have port done  output  1  one-cycle pulse at the end of each frame's last stop bit.
REQ-012 SHALL have port err  output  1  one-cycle pulse when start is asserted while ready is low.

Function
REQ-013 SHALL use states IDLE, START_BIT, DATA_BITS, PARITY_BIT (macro only), STOP_BIT.
REQ-014 SHALL hold each bit on out for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that wraps to 0 at CLKS_PER_BIT-1.
REQ-015 SHALL provide a one-byte holding register: start && ready latches in and clears ready on the next cycle.
REQ-016 SHALL, in IDLE with the holding register full, move the byte to the shift register, refill ready, enter START_BIT, and drive out low on the next cycle.
REQ-017 SHALL give latency of 2 cycles from an accepted start in IDLE to the first low cycle on out.
REQ-018 SHALL send data bits LSB first in DATA_BITS, using a 3-bit index that wraps 7->0 on leaving DATA_BITS.
REQ-019 SHALL drive out high in STOP_BIT for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 SHALL pulse done in the last STOP_BIT cycle.
REQ-021 SHALL, if the holding register is full at the end of STOP_BIT, enter START_BIT directly with no idle cycle (back-to-back); otherwise it SHALL enter IDLE.
REQ-022 SHALL assert busy from the first START_BIT cycle through the last STOP_BIT cycle, and deassert it in IDLE.
REQ-023 SHALL, when start is asserted and ready is low, ignore the byte, leave the holding register unchanged, and pulse err on the next cycle.
REQ-024 SHALL, for start asserted in the same cycle the holding register empties, honour the ready value registered for that cycle (accept only if ready is high).
REQ-025 SHALL, with en low, enter IDLE immediately, drive out high, empty the holding register, and clear counters, without pulsing done.
REQ-026 SHALL ignore start while en is low.

Reset
REQ-027 SHALL, on rst high at posedge clk, set out=1, ready=1, busy=0, done=0, err=0, state=IDLE, counters=0, and holding/shift registers=0.
REQ-028 SHALL abort a frame on rst mid-frame, returning out high on the next cycle with no done pulse.
REQ-029 SHALL give rst priority over en and start.

Configuration
REQ-030 SHALL, with macro UART8_TX_PARITY_EN defined, insert PARITY_BIT between DATA_BITS and STOP_BIT, carrying the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-031 SHALL, with UART8_TX_PARITY_EN undefined, go from DATA_BITS directly to STOP_BIT, with the frame 10 bits long at STOP_BITS=1.

Verification
REQ-032 SHALL cover: defaults, no parity, start with in=0xA5 in IDLE -> out low for cycles 2-17, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop high 16 cycles, done pulse at cycle 161, busy high cycles 2-161.
REQ-033 SHALL cover: UART8_TX_PARITY_EN defined, in=0xA5 -> parity bit 0 after bit 7; in=0x07 -> parity bit 1; done is 16 cycles later than without parity.
REQ-034 SHALL cover: 0x55 accepted, then 0x0F accepted while busy -> ready low until 0x0F enters the shift register; second start bit follows the first frame's stop bit with zero idle cycles; two done pulses 160 cycles apart.
REQ-035 SHALL cover: third start while the holding register is full -> err pulses once, and the transmitted bytes are unchanged (0x55, 0x0F only).
REQ-036 SHALL cover: rst asserted at cycle 50 of the 0xA5 frame -> out=1 and ready=1 the next cycle, busy=0, no done; a new start afterwards sends a complete correct frame.
REQ-037 SHALL cover: en dropped mid-frame -> out high next cycle, holding register emptied, no done; start with en low -> no frame.
